// File: rtl/multn.sv
// Word-serial WIDTH x WIDTH unsigned multiplier behind a GPIO-style register window.
// Optional MULT_CYCLE_COUNT_EN adds a run-cycle counter readable at index 0xFFFF.
module multn #(
  parameter int WIDTH = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_loc,
  input  logic [31:0] in_val,
  input  logic [31:0] ctrl_reg,
  output logic [31:0] out_loc,
  output logic [31:0] out_val,
  output logic [31:0] state_reg
);
  localparam int N  = WIDTH / 32;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(2 * N);

  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_START = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_BUSY, S_DONE} st_t;

  st_t                    st_q;
  logic [N-1:0][31:0]     a_q, b_q;
  logic [2*N-1:0][31:0]   r_q;
  logic [IW-1:0]          i_q, j_q;
  logic [31:0]            c_q;
  logic                   tog_q, err_q;
  logic [15:0]            ack_q;
`ifdef MULT_CYCLE_COUNT_EN
  logic [31:0]            cyc_q;
`endif

  logic          cmd, busy, idx_ok;
  logic [2:0]    op;
  logic [15:0]   idx;
  logic [RW-1:0] k, k1;
  logic [31:0]   cin;
  logic [63:0]   prod, mac;
  logic [1:0]    st_code;
  logic          unused_ok;

  assign cmd    = ctrl_reg[31] ^ tog_q;
  assign op     = ctrl_reg[2:0];
  assign idx    = in_loc[15:0];
  assign idx_ok = idx < 16'(N);
  assign busy   = (st_q == S_CLR) || (st_q == S_BUSY);

  // One 32x32 MAC per cycle; the 64-bit sum cannot overflow.
  assign k    = RW'(i_q) + RW'(j_q);
  assign k1   = k + RW'(1);
  assign cin  = (i_q == '0) ? 32'd0 : c_q;
  assign prod = {32'd0, a_q[i_q]} * {32'd0, b_q[j_q]};
  assign mac  = prod + {32'd0, r_q[k]} + {32'd0, cin};

  always_comb begin
    st_code = 2'd0;
    case (st_q)
      S_CLR, S_BUSY: st_code = 2'd1;
      S_DONE:        st_code = 2'd2;
      default:       st_code = 2'd0;
    endcase
  end

  assign state_reg = {ack_q, 7'd0, err_q, 6'd0, st_code};
  assign unused_ok = ^ctrl_reg[30:3];

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      c_q     <= '0;
      tog_q   <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      out_loc <= '0;
      out_val <= '0;
`ifdef MULT_CYCLE_COUNT_EN
      cyc_q   <= '0;
`endif
    end else begin
`ifdef MULT_CYCLE_COUNT_EN
      if (busy && cyc_q != '1) cyc_q <= cyc_q + 32'd1;
`endif
      case (st_q)
        S_CLR: begin
          r_q  <= '0;
          i_q  <= '0;
          j_q  <= '0;
          c_q  <= '0;
          st_q <= S_BUSY;
        end
        S_BUSY: begin
          r_q[k] <= mac[31:0];
          c_q    <= mac[63:32];
          if (i_q == IW'(N - 1)) begin
            r_q[k1] <= mac[63:32];
            i_q     <= '0;
            j_q     <= j_q + 1'b1;
            if (j_q == IW'(N - 1)) st_q <= S_DONE;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        default: ;
      endcase

      // Commands come last so CLEAR overrides an in-flight step.
      if (cmd) begin
        tog_q <= ctrl_reg[31];
        ack_q <= ack_q + 16'd1;
        case (op)
          OP_WRITE: begin
            if (!idx_ok || busy) err_q <= 1'b1;
            else if (in_loc[16]) b_q[idx[IW-1:0]] <= in_val;
            else                 a_q[idx[IW-1:0]] <= in_val;
          end
          OP_START: begin
            if (busy) err_q <= 1'b1;
            else begin
              st_q <= S_CLR;
`ifdef MULT_CYCLE_COUNT_EN
              cyc_q <= '0;
`endif
            end
          end
          OP_CLEAR: begin
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            err_q <= 1'b0;
            st_q  <= S_IDLE;
          end
          default: ;
        endcase
      end

      out_loc <= in_loc;
      if (idx < 16'(2 * N)) out_val <= r_q[idx[RW-1:0]];
`ifdef MULT_CYCLE_COUNT_EN
      else if (idx == 16'hFFFF) out_val <= cyc_q;
`endif
      else out_val <= '0;
    end
  end
endmodule

// File: tb/tb_multn.sv
// Randomized self-checking bench for multn against a wide-arithmetic reference product.
module tb_multn;
  localparam int WIDTH = 128;
  localparam int N     = WIDTH / 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_loc, in_val, ctrl_reg;
  logic [31:0] out_loc, out_val, state_reg;

  int total = 0;
  int bad   = 0;

  logic                 tog = 1'b0;
  logic [15:0]          mack = '0;
  logic                 merr = 1'b0;
  logic [WIDTH-1:0]     ma = '0, mb = '0;
  logic [2*WIDTH-1:0]   mr = '0;

  multn #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_loc(in_loc), .in_val(in_val),
    .ctrl_reg(ctrl_reg), .out_loc(out_loc), .out_val(out_val),
    .state_reg(state_reg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st(input logic [1:0] code);
    return {mack, 7'd0, merr, 6'd0, code};
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] loc, input logic [31:0] val);
    tog      = ~tog;
    in_loc   = loc;
    in_val   = val;
    ctrl_reg = {tog, 28'd0, op};
    tick();
    mack++;
  endtask

  task automatic write_ops;
    for (int w = 0; w < N; w++) begin
      issue(3'd1, {15'd0, 1'b0, 16'(w)}, ma[32*w +: 32]);
      issue(3'd1, {15'd0, 1'b1, 16'(w)}, mb[32*w +: 32]);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (state_reg[1:0] != 2'd2 && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic run_mult;
    int n;
    issue(3'd2, 32'd0, 32'd0);
    chk("start_busy", state_reg, st(2'd1));
    wait_done(n);
    chk("latency", 64'(n), 64'(N * N + 1));
    mr = {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
    chk("done_state", state_reg, st(2'd2));
  endtask

  task automatic read_all(input string tag);
    for (int w = 0; w < 2 * N; w++) begin
      in_loc = 32'(w);
      tick();
      chk({tag, "_loc"}, out_loc, 64'(w));
      chk({tag, "_val"}, out_val, mr[32*w +: 32]);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; ctrl_reg = '0; in_loc = 32'h5; in_val = '0;
    repeat (3) tick();
    chk("rst_loc", out_loc, 0);
    chk("rst_val", out_val, 0);
    chk("rst_state", state_reg, 0);

    // toggle held high through reset executes one NOP on release
    tog = 1'b1; ctrl_reg = 32'h8000_0000;
    tick();
    reset = 1'b0;
    tick();
    mack = 16'd1;
    chk("rel_nop", state_reg, st(2'd0));

    ma = '1; mb = '1;
    write_ops();
    chk("wr_state", state_reg, st(2'd0));
    run_mult();
    read_all("ones");
    chk("ones_r4", mr[159:128], 32'hFFFF_FFFE);

    in_loc = 32'(2 * N); tick();
    chk("oor_val", out_val, 0);
    in_loc = 32'h0000_FFFF; tick();
`ifdef MULT_CYCLE_COUNT_EN
    chk("cyc_cnt", out_val, 64'(N * N + 1));
`else
    chk("cyc_cnt", out_val, 0);
`endif
    in_loc = 32'h0001_0003; tick();
    chk("hi_loc", out_loc, 32'h0001_0003);
    chk("hi_val", out_val, mr[127:96]);

    for (int r = 0; r < 5; r++) begin
      for (int w = 0; w < N; w++) begin
        ma[32*w +: 32] = $urandom;
        mb[32*w +: 32] = $urandom;
      end
      if (r == 0) begin ma = WIDTH'(1) << 32; mb = WIDTH'(3); end
      if (r == 1) mb = WIDTH'(5);
      if (r == 2) mb = '0;
      write_ops();
      run_mult();
      read_all("rnd");
    end

    issue(3'd1, {15'd0, 1'b0, 16'(N)}, 32'hDEAD_BEEF);
    merr = 1'b1;
    chk("err_idx", state_reg, st(2'd2));
    issue(3'd3, 32'd0, 32'd0);
    merr = 1'b0; ma = '0; mb = '0; mr = '0;
    chk("clear_state", state_reg, st(2'd0));
    read_all("clr");

    for (int w = 0; w < N; w++) begin
      ma[32*w +: 32] = $urandom;
      mb[32*w +: 32] = $urandom;
    end
    write_ops();
    issue(3'd2, 32'd0, 32'd0);
    tick();
    issue(3'd2, 32'd0, 32'd0);
    merr = 1'b1;
    chk("err_start", state_reg, st(2'd1));
    issue(3'd1, 32'd0, 32'h1234_5678);
    wait_done(n);
    chk("busy_bound", 64'(n < 400), 1);
    mr = {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
    read_all("busyerr");
    run_mult();
    read_all("rerun");

    for (int t = 0; t < 3; t++) issue(3'd6, 32'd0, 32'd0);
    chk("nop6", state_reg, st(2'd2));

    issue(3'd2, 32'd0, 32'd0);
    repeat (5) tick();
    issue(3'd3, 32'd0, 32'd0);
    merr = 1'b0; ma = '0; mb = '0; mr = '0;
    chk("abort", state_reg, st(2'd0));
    repeat (3) tick();
    read_all("abort");

    ma = '1; mb = WIDTH'(7);
    write_ops();
    issue(3'd2, 32'd0, 32'd0);
    repeat (4) tick();
    in_loc = 32'd3;
    reset = 1'b1;
    tick();
    chk("mid_rst_loc", out_loc, 0);
    chk("mid_rst_val", out_val, 0);
    chk("mid_rst_state", state_reg, 0);
    ctrl_reg = '0; tog = 1'b0;
    tick();
    reset = 1'b0;
    mack = '0; merr = 1'b0; ma = '0; mb = '0; mr = '0;
    tick();
    chk("post_rst", state_reg, st(2'd0));
    read_all("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multn.md
# multn

Parametrised word-serial unsigned multiplier, WIDTH×WIDTH → 2·WIDTH bits, driven over the 32-bit MicroBlaze MCS GPIO register interface: in_loc/in_val/ctrl_reg come from GPIO outputs; out_loc/out_val/state_reg go to GPIO inputs. It generalises the fixed 128-bit multiplier in three ways: operand width is a parameter, commands use an explicit toggle handshake with an acknowledge counter, and illegal accesses are flagged in an error bit. One 32×32 multiply-accumulate step runs per clock.

## Interface
- WIDTH, 128, operand width in bits; multiple of 32, range 64..1024; N = WIDTH/32 operand words, 2N result words
- clk  input  1  system clock (100 MHz); the only clock
- reset  input  1  synchronous, active-high
- in_loc  input  32  [15:0] word index; [16] operand select (0 = A, 1 = B)
- in_val  input  32  operand word data for WRITE
- ctrl_reg  input  32  [2:0] opcode; [31] command toggle
- out_loc  output  32  registered copy of in_loc that out_val corresponds to
- out_val  output  32  registered result word at index in_loc[15:0]
- state_reg  output  32  [1:0] state (0 IDLE, 1 BUSY, 2 DONE); [8] error; [31:16] acknowledge counter

## Operation
- Command issue: any transition of ctrl_reg[31] relative to its registered copy executes ctrl_reg[2:0] once. Opcodes: 0 NOP, 1 WRITE, 2 START, 3 CLEAR, 4–7 treated as NOP.
- Acknowledge counter increments by 1 (mod 2^16) for every detected toggle, including NOP and rejected commands.
- WRITE: A[idx] or B[idx] ← in_val. Rejected (error ← 1, no write) if idx ≥ N or state = BUSY.
- START: from IDLE or DONE → CLR. Rejected (error ← 1) while BUSY.
- CLEAR: accepted in any state, including BUSY (aborts). Zeroes A, B, result and error; state ← IDLE.
- States:
  - IDLE
  - CLR: one cycle; result ← 0; i = j = 0; reports as BUSY
  - BUSY
  - DONE
- BUSY step for (i, j):
  - {c, R[i+j]} ← R[i+j] + A[i]·B[j] + c (64-bit; cannot overflow); c ← 0 at i = 0
  - at i = N−1 also R[i+j+1] ← high word; then i ← 0, j ← j+1
  - after (N−1, N−1): → DONE
- Readout every cycle:
  - out_loc ← in_loc
  - out_val ← R[in_loc[15:0]] if index < 2N, else 0
  - values read during BUSY are partial sums
- Error bit is sticky until CLEAR or reset.
- Operand words keep their values through START/DONE and can be rewritten in IDLE or DONE; state is unchanged by WRITE.

## Timing
- Reset: out_loc, out_val, state_reg = 0; A, B, R, toggle copy, error, counter = 0. If ctrl_reg[31] = 1 while reset is asserted, one command executes on the first cycle after release.
- Reset mid-operation: abort; everything returns to reset values.
- Command detect → effect: 1 cycle. The toggle copy, counter and register writes update on the same edge.
- START latency: toggle seen at edge t. CLR at t+1, then N² BUSY cycles, state_reg[1:0] = 2 from edge t+1+N². For WIDTH = 128 that is 17 cycles.
- Readout latency: 1 cycle from in_loc to out_loc/out_val.
- Simultaneous events:
  - a toggle in the cycle BUSY finishes sees state BUSY and is judged as BUSY
  - reset overrides every command

## Configuration
- MULT_CYCLE_COUNT_EN defined:
  - adds a 32-bit counter that clears on START and increments every CLR/BUSY cycle
  - the counter is readable at index 0xFFFF (out_val), saturating at 2^32−1
- Without MULT_CYCLE_COUNT_EN: no counter; index 0xFFFF returns 0 like any out-of-range index.

## Test plan
- WIDTH = 128, A = B = 2^128−1 via 8 WRITEs, START → DONE after exactly 17 cycles; R[7..0] = FFFFFFFF,FFFFFFFF,FFFFFFFF,FFFFFFFE,00000000,00000000,00000000,00000001; counter = 9.
- WIDTH = 64, A = 0x1_00000000, B = 3 → R = {0,3,0} in words [2:0], DONE after 5 cycles; restart with B = 5 → R[1] = 5.
- WRITE with idx = N, then START during BUSY → error = 1, operands unchanged, result unaffected; CLEAR → error = 0, state IDLE, all R = 0.
- Toggle ctrl_reg[31] with opcode 6 three times → counter = 3, no state change; reset asserted mid-BUSY → all outputs 0 the next cycle.
- With MULT_CYCLE_COUNT_EN and WIDTH = 256, read index 0xFFFF after DONE → 65; without the macro → 0.
